pwm_preconditioner: RTL

- Consumer end of the silent filter output. Takes the smoothed per-transducer DUTY_S/PHASE_S plus CYCLE and converts them into absolute RISE/FALL edge times for the PWM timers.
- Processes one channel per clock, time-multiplexed across DEPTH channels.
- Commits all DEPTH results atomically, so the PWM stage never sees a mix of old and new edges.
- Sits between silent and the per-channel PWM counters.

---
 rtl/pwm_pkg.sv | 20 ++
 rtl/pwm_edge_calc.sv | 72 +++++++
 rtl/pwm_preconditioner.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared types and constants for the pwm_preconditioner slice: sweep FSM states,
// pipeline latency and the {rise, fall} pair stored in the commit shadow.
package pwm_pkg;

  localparam int unsigned PIPE_LAT = 3;
  localparam int unsigned EDGE_W   = 13;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWEEP  = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } pwm_state_t;

  typedef struct packed {
    logic [EDGE_W-1:0] rise;
    logic [EDGE_W-1:0] fall;
  } edge_pair_t;

endpackage

// File: rtl/pwm_edge_calc.sv
// S1-S2 arithmetic of the preconditioner: clamps duty to the period, halves it,
// and centres the pulse on the phase, wrapping both edges into [0, C).
module pwm_edge_calc #(
  parameter int WIDTH = 13,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] p,
  input  logic             valid,
  input  logic [IDX_W-1:0] idx,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             res_valid,
  output logic [IDX_W-1:0] res_idx
);

  logic [WIDTH-1:0] dc_s, hlo_s, hhi_s;
  logic [WIDTH-1:0] c_r, p_r, hlo_r, hhi_r;
  logic             valid_r;
  logic [IDX_W-1:0] idx_r;
  logic [WIDTH:0]   c_w_s, rise_sum_s, fall_sum_s;

  // S1 combinational: clamp and split the duty into lower/upper halves
  always_comb begin
    if (d > c) begin
      dc_s = c;
    end else begin
      dc_s = d;
    end
    hlo_s = {1'b0, dc_s[WIDTH-1:1]};
    hhi_s = hlo_s + WIDTH'(dc_s[0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid;
    end
  end

  always_ff @(posedge clk) begin
    c_r   <= c;
    p_r   <= p;
    hlo_r <= hlo_s;
    hhi_r <= hhi_s;
    idx_r <= idx;
  end

  // S2: sums fit WIDTH+1 bits and stay below 2C, so one conditional wrap suffices
  always_comb begin
    c_w_s      = {1'b0, c_r};
    rise_sum_s = {1'b0, p_r} + c_w_s - {1'b0, hlo_r};
    fall_sum_s = {1'b0, p_r} + {1'b0, hhi_r};
    if (rise_sum_s >= c_w_s) begin
      rise = rise_sum_s[WIDTH-1:0] - c_r;
    end else begin
      rise = rise_sum_s[WIDTH-1:0];
    end
    if (fall_sum_s >= c_w_s) begin
      fall = fall_sum_s[WIDTH-1:0] - c_r;
    end else begin
      fall = fall_sum_s[WIDTH-1:0];
    end
    res_valid = valid_r;
    res_idx   = idx_r;
  end

endmodule

// File: rtl/pwm_preconditioner.sv
// Time-multiplexed duty/phase -> rise/fall converter with an atomic commit of all channels.
// Optional dropped-START counter enabled by PWM_PRECONDITIONER_OVERRUN_CNT_EN.
module pwm_preconditioner
  import pwm_pkg::*;
#(
  parameter int WIDTH = 13,
  parameter int DEPTH = 249
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] cycle [DEPTH],
  input  logic [WIDTH-1:0] duty  [DEPTH],
  input  logic [WIDTH-1:0] phase [DEPTH],
  output logic [WIDTH-1:0] rise  [DEPTH],
  output logic [WIDTH-1:0] fall  [DEPTH],
  output logic             busy,
  output logic             done
`ifdef PWM_PRECONDITIONER_OVERRUN_CNT_EN
  ,
  output logic [15:0]      overrun_cnt
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DEPTH - 1);
  localparam logic [1:0]       DRAIN_LAST = 2'(PIPE_LAT - 2);

  pwm_state_t       state_r, state_s;
  logic [IDX_W-1:0] idx_r, idx_s;
  logic [1:0]       drain_r, drain_s;
  logic             pending_r, pending_s;
  logic             issue_s, commit_s;

  logic             s0_valid_r;
  logic [IDX_W-1:0] s0_idx_r;
  logic [WIDTH-1:0] s0_c_r, s0_d_r, s0_p_r;

  logic [WIDTH-1:0] calc_rise_s, calc_fall_s;
  logic             calc_valid_s;
  logic [IDX_W-1:0] calc_idx_s;

  edge_pair_t       shadow_r [DEPTH];

  // Sweep sequencing; a START seen while busy is remembered once in pending
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    drain_s   = drain_r;
    pending_s = pending_r;
    issue_s   = 1'b0;
    commit_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = SWEEP;
          idx_s   = '0;
        end else begin
          state_s = IDLE;
        end
      end
      SWEEP: begin
        issue_s = 1'b1;
        if (start && !pending_r) pending_s = 1'b1;
        else                     pending_s = pending_r;
        if (idx_r == IDX_LAST) begin
          state_s = DRAIN;
          drain_s = 2'd0;
        end else begin
          idx_s = idx_r + IDX_W'(1);
        end
      end
      DRAIN: begin
        if (start && !pending_r) pending_s = 1'b1;
        else                     pending_s = pending_r;
        if (drain_r == DRAIN_LAST) begin
          state_s = COMMIT;
        end else begin
          drain_s = drain_r + 2'd1;
        end
      end
      COMMIT: begin
        commit_s  = 1'b1;
        idx_s     = '0;
        pending_s = 1'b0;
        if (pending_r || start) state_s = SWEEP;
        else                    state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      idx_r     <= '0;
      drain_r   <= 2'd0;
      pending_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      idx_r     <= idx_s;
      drain_r   <= drain_s;
      pending_r <= pending_s;
    end
  end

  // S0: inputs are sampled live at the cycle the channel is issued
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid_r <= 1'b0;
    end else begin
      s0_valid_r <= issue_s;
    end
  end

  always_ff @(posedge clk) begin
    s0_idx_r <= idx_r;
    s0_c_r   <= cycle[idx_r];
    s0_d_r   <= duty[idx_r];
    s0_p_r   <= phase[idx_r];
  end

  pwm_edge_calc #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_edge_calc (
    .clk       (clk),
    .rst       (rst),
    .c         (s0_c_r),
    .d         (s0_d_r),
    .p         (s0_p_r),
    .valid     (s0_valid_r),
    .idx       (s0_idx_r),
    .rise      (calc_rise_s),
    .fall      (calc_fall_s),
    .res_valid (calc_valid_s),
    .res_idx   (calc_idx_s)
  );

  // Shadow needs no reset: every entry is rewritten before the next commit
  always_ff @(posedge clk) begin
    if (calc_valid_s) begin
      shadow_r[calc_idx_s] <= '{rise: calc_rise_s, fall: calc_fall_s};
    end
  end

  // busy/done describe the cycle just completed, so done and new edges appear together
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        rise[i] <= '0;
        fall[i] <= '0;
      end
    end else begin
      busy <= (state_r != IDLE);
      done <= commit_s;
      if (commit_s) begin
        for (int i = 0; i < DEPTH; i++) begin
          rise[i] <= shadow_r[i].rise;
          fall[i] <= shadow_r[i].fall;
        end
      end
    end
  end

`ifdef PWM_PRECONDITIONER_OVERRUN_CNT_EN
  logic drop_s;
  assign drop_s = start && pending_r && (state_r != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_cnt <= 16'd0;
    end else if (drop_s && (overrun_cnt != 16'hFFFF)) begin
      overrun_cnt <= overrun_cnt + 16'd1;
    end else begin
      overrun_cnt <= overrun_cnt;
    end
  end
`endif

endmodule
